// File: rtl/mac_result_divider_if.sv
// Handshake and operand/result bundle for mac_result_divider.
// master: the block issuing divisions; slave: the divider itself.
interface mac_result_divider_if #(
    parameter int N_WIDTH = 16,
    parameter int D_WIDTH = 8
);
    logic               start;
    logic [N_WIDTH-1:0] dividend;
    logic [D_WIDTH-1:0] divisor;
    logic               busy;
    logic               done;
    logic [N_WIDTH-1:0] quotient;
    logic [D_WIDTH-1:0] remainder;
    logic               div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/mac_result_divider.sv
// mac_result_divider: sequential restoring divider recovering Q = N / D and
// R = N % D from a multiply-add result word, one quotient bit per clock.
// Optional feature macro: DIV_ZERO_DETECT_EN -- when defined, a zero divisor
// finishes one edge after acceptance with the div_by_zero flag raised;
// otherwise a zero divisor runs the full iteration count and the flag stays 0.
module mac_result_divider #(
    parameter int N_WIDTH = 16,
    parameter int D_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mac_result_divider_if.slave   bus
);

    localparam int CNT_W = $clog2(N_WIDTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef DIV_ZERO_DETECT_EN
    localparam logic DZ_EN = 1'b1;
`else
    localparam logic DZ_EN = 1'b0;
`endif

    // State and datapath registers
    logic [0:0]         state_q,  state_d;
    logic [N_WIDTH-1:0] dvd_q,    dvd_d;     // dividend shift register
    logic [D_WIDTH-1:0] dvs_q,    dvs_d;     // divisor holding register
    logic [D_WIDTH:0]   p_q,      p_d;       // partial remainder
    logic [N_WIDTH-1:0] q_q,      q_d;       // quotient accumulator
    logic [CNT_W-1:0]   cnt_q,    cnt_d;     // iteration counter
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [N_WIDTH-1:0] quot_q,   quot_d;
    logic [D_WIDTH-1:0] rem_q,    rem_d;
    logic               dbz_q,    dbz_d;

    // Single restoring step
    logic [D_WIDTH+1:0] p_shift_s;
    logic [D_WIDTH:0]   p_sub_s;
    logic [D_WIDTH:0]   p_next_s;
    logic               qbit_s;
    logic               last_s;
    logic               zero_div_s;

    // Compute one restoring iteration from the current partial remainder
    always_comb begin
        p_shift_s = {p_q, dvd_q[N_WIDTH-1]};
        p_sub_s   = p_shift_s[D_WIDTH:0] - {1'b0, dvs_q};
        if (p_shift_s >= {2'b00, dvs_q}) begin
            qbit_s   = 1'b1;
            p_next_s = p_sub_s;
        end else begin
            qbit_s   = 1'b0;
            p_next_s = p_shift_s[D_WIDTH:0];
        end
        last_s     = (cnt_q == CNT_W'(N_WIDTH - 1));
        zero_div_s = DZ_EN && (dvs_q == {D_WIDTH{1'b0}});
    end

    // Next-state logic for the IDLE/RUN controller and datapath
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    p_d     = {(D_WIDTH+1){1'b0}};
                    q_d     = {N_WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (zero_div_s) begin
                    // Zero divisor short-circuits to the result the full
                    // iteration would have produced.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quot_d  = {N_WIDTH{1'b1}};
                    rem_d   = dvd_q[D_WIDTH-1:0];
                    dbz_d   = 1'b1;
                end else begin
                    dvd_d = {dvd_q[N_WIDTH-2:0], 1'b0};
                    p_d   = p_next_s;
                    q_d   = {q_q[N_WIDTH-2:0], qbit_s};
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        quot_d  = {q_q[N_WIDTH-2:0], qbit_s};
                        rem_d   = p_next_s[D_WIDTH-1:0];
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dvd_q   <= {N_WIDTH{1'b0}};
            dvs_q   <= {D_WIDTH{1'b0}};
            p_q     <= {(D_WIDTH+1){1'b0}};
            q_q     <= {N_WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= {N_WIDTH{1'b0}};
            rem_q   <= {D_WIDTH{1'b0}};
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mac_result_divider.sv
// Directed self-checking bench for mac_result_divider.
module tb_mac_result_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mac_result_divider_if #(.N_WIDTH(16), .D_WIDTH(8)) bus_if ();

    mac_result_divider #(.N_WIDTH(16), .D_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Present operands and hold start across one rising edge (edge k).
    task automatic issue(input logic [15:0] n, input logic [7:0] d);
        bus_if.dividend = n;
        bus_if.divisor  = d;
        bus_if.start    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start    = 1'b0;
    endtask

    // Count edges until done is seen (bounded); lat = -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) begin
                lat = i;
                break;
            end
            if (bus_if.busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        bus_if.start = 1'b1; bus_if.dividend = 16'd30100; bus_if.divisor = 8'd150;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
        n_checks++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus_if.done); end
        n_checks++; if (bus_if.quotient !== 16'd0) begin n_fail++; $display("FAIL reset_q: got %0d expected 0", bus_if.quotient); end
        n_checks++; if (bus_if.remainder !== 8'd0) begin n_fail++; $display("FAIL reset_r: got %0d expected 0", bus_if.remainder); end
        n_checks++; if (bus_if.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", bus_if.div_by_zero); end
        bus_if.start = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", bus_if.busy); end
        n_checks++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL idle_done: got %b expected 0", bus_if.done); end
    endtask

    task automatic test_basic();
        int lat, bc;
        issue(16'd30100, 8'd150);
        n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start: got %b expected 1", bus_if.busy); end
        wait_done(lat, bc);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL basic_latency: got %0d expected 16", lat); end
        n_checks++; if (bc !== 15) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 15", bc); end
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b expected 0", bus_if.busy); end
        n_checks++; if (bus_if.quotient !== 16'd200) begin n_fail++; $display("FAIL basic_q: got %0d expected 200", bus_if.quotient); end
        n_checks++; if (bus_if.remainder !== 8'd100) begin n_fail++; $display("FAIL basic_r: got %0d expected 100", bus_if.remainder); end
        @(posedge clk); #1;
        n_checks++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", bus_if.done); end
        n_checks++; if (bus_if.quotient !== 16'd200) begin n_fail++; $display("FAIL basic_q_hold: got %0d expected 200", bus_if.quotient); end
    endtask

    task automatic test_wide();
        int lat, bc;
        issue(16'd65280, 8'd255);
        n_checks++; if (bus_if.quotient !== 16'd200) begin n_fail++; $display("FAIL wide_q_unchanged_at_start: got %0d expected 200", bus_if.quotient); end
        wait_done(lat, bc);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL wide_latency: got %0d expected 16", lat); end
        n_checks++; if (bus_if.quotient !== 16'd256) begin n_fail++; $display("FAIL wide_q: got %0d expected 256", bus_if.quotient); end
        n_checks++; if (bus_if.remainder !== 8'd0) begin n_fail++; $display("FAIL wide_r: got %0d expected 0", bus_if.remainder); end
        issue(16'd7, 8'd9);
        wait_done(lat, bc);
        n_checks++; if (bus_if.quotient !== 16'd0) begin n_fail++; $display("FAIL small_q: got %0d expected 0", bus_if.quotient); end
        n_checks++; if (bus_if.remainder !== 8'd7) begin n_fail++; $display("FAIL small_r: got %0d expected 7", bus_if.remainder); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        int exp_lat;
        logic exp_dbz;
`ifdef DIV_ZERO_DETECT_EN
        exp_lat = 1;  exp_dbz = 1'b1;
`else
        exp_lat = 16; exp_dbz = 1'b0;
`endif
        issue(16'h1234, 8'd0);
        wait_done(lat, bc);
        n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL dz_latency: got %0d expected %0d", lat, exp_lat); end
        n_checks++; if (bus_if.quotient !== 16'hFFFF) begin n_fail++; $display("FAIL dz_q: got %h expected ffff", bus_if.quotient); end
        n_checks++; if (bus_if.remainder !== 8'h34) begin n_fail++; $display("FAIL dz_r: got %h expected 34", bus_if.remainder); end
        n_checks++; if (bus_if.div_by_zero !== exp_dbz) begin n_fail++; $display("FAIL dz_flag: got %b expected %b", bus_if.div_by_zero, exp_dbz); end
        repeat (2) @(posedge clk); #1;
        n_checks++; if (bus_if.div_by_zero !== exp_dbz) begin n_fail++; $display("FAIL dz_flag_hold: got %b expected %b", bus_if.div_by_zero, exp_dbz); end
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        issue(16'd30100, 8'd150);
        n_checks++; if (bus_if.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_flag_clear: got %b expected 0", bus_if.div_by_zero); end
        repeat (4) @(posedge clk);
        #1;
        bus_if.dividend = 16'd1000; bus_if.divisor = 8'd7; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        wait_done(lat, bc);
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 11", lat); end
        n_checks++; if (bus_if.quotient !== 16'd200) begin n_fail++; $display("FAIL ignore_q: got %0d expected 200", bus_if.quotient); end
        n_checks++; if (bus_if.remainder !== 8'd100) begin n_fail++; $display("FAIL ignore_r: got %0d expected 100", bus_if.remainder); end
        @(posedge clk); #1;
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queue: got %b expected 0", bus_if.busy); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        bus_if.dividend = 16'd65280; bus_if.divisor = 8'd255; bus_if.start = 1'b1;
        @(posedge clk); #1;
        wait_done(lat, bc);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 16", lat); end
        n_checks++; if (bus_if.quotient !== 16'd256) begin n_fail++; $display("FAIL b2b_first_q: got %0d expected 256", bus_if.quotient); end
        bus_if.dividend = 16'd1000; bus_if.divisor = 8'd7;
        wait_done(lat, bc);
        bus_if.start = 1'b0;
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 17", lat); end
        n_checks++; if (bc !== 16) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 16", bc); end
        n_checks++; if (bus_if.quotient !== 16'd142) begin n_fail++; $display("FAIL b2b_second_q: got %0d expected 142", bus_if.quotient); end
        n_checks++; if (bus_if.remainder !== 8'd6) begin n_fail++; $display("FAIL b2b_second_r: got %0d expected 6", bus_if.remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_abort();
        int lat, bc;
        int done_seen;
        issue(16'd30100, 8'd150);
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus_if.busy); end
        n_checks++; if (bus_if.quotient !== 16'd0) begin n_fail++; $display("FAIL abort_q: got %0d expected 0", bus_if.quotient); end
        n_checks++; if (bus_if.remainder !== 8'd0) begin n_fail++; $display("FAIL abort_r: got %0d expected 0", bus_if.remainder); end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus_if.done || bus_if.busy) done_seen++;
        end
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", done_seen); end
        issue(16'd1000, 8'd7);
        wait_done(lat, bc);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL after_abort_latency: got %0d expected 16", lat); end
        n_checks++; if (bus_if.quotient !== 16'd142) begin n_fail++; $display("FAIL after_abort_q: got %0d expected 142", bus_if.quotient); end
        n_checks++; if (bus_if.remainder !== 8'd6) begin n_fail++; $display("FAIL after_abort_r: got %0d expected 6", bus_if.remainder); end
    endtask

    // Run every scenario in sequence, then report
    initial begin
        bus_if.start = 1'b0;
        bus_if.dividend = 16'd0;
        bus_if.divisor = 8'd0;
        test_reset();
        test_basic();
        test_wide();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_rst_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
